// File: rtl/interval_hist_if.sv
// Handshake bundle for interval_hist: one-hot interval beats in, histogram entries out.
// master = upstream/downstream environment, slave = interval_hist.
interface interval_hist_if #(
   parameter int NUM   = 8,
   parameter int CNT_W = 16
);
   localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

   logic             valid_i;
   logic             ready_o;
   logic [NUM-1:0]   interval_i;
   logic             last_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [IDX_W-1:0] bin_o;
   logic [CNT_W-1:0] count_o;
   logic             out_last_o;
   logic             error_o;

   modport master (
      output valid_i, interval_i, last_i, out_ready_i,
      input  ready_o, out_valid_o, bin_o, count_o, out_last_o, error_o
   );

   modport slave (
      input  valid_i, interval_i, last_i, out_ready_i,
      output ready_o, out_valid_o, bin_o, count_o, out_last_o, error_o
   );
endinterface

// File: rtl/interval_hist.sv
// Per-frame histogram of one-hot interval codes, drained bin by bin after the last beat.
// Define INTERVAL_HIST_SAT_EN to make counters saturate instead of wrapping.
module interval_hist #(
   parameter int NUM   = 8,
   parameter int CNT_W = 16
) (
   input logic           clk_i,
   input logic           rst_ni,
   interval_hist_if.slave bus
);
   localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

   typedef enum logic {ACC, DUMP} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q [NUM];
   logic [CNT_W-1:0] cnt_d [NUM];
   logic             error_q, error_d;

   logic accept;
   logic onehot;
   logic idx_last;

   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef INTERVAL_HIST_SAT_EN
      return (c == '1) ? c : c + CNT_W'(1);
`else
      return c + CNT_W'(1);
`endif
   endfunction

   assign accept   = bus.valid_i && (state_q == ACC);
   assign onehot   = (bus.interval_i != '0) &&
                     ((bus.interval_i & (bus.interval_i - NUM'(1))) == '0);
   assign idx_last = (idx_q == IDX_W'(NUM - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      error_d = error_q;
      for (int unsigned k = 0; k < NUM; k++) cnt_d[k] = cnt_q[k];

      case (state_q)
         ACC: begin
            if (accept) begin
               if (onehot) begin
                  for (int unsigned k = 0; k < NUM; k++)
                     if (bus.interval_i[k]) cnt_d[k] = bump(cnt_q[k]);
               end else begin
                  error_d = 1'b1;
               end
               if (bus.last_i) begin
                  state_d = DUMP;
                  idx_d   = '0;
               end
            end
         end
         DUMP: begin
            if (bus.out_ready_i) begin
               if (idx_last) begin
                  // Final entry taken: start the next frame from a clean slate.
                  state_d = ACC;
                  idx_d   = '0;
                  error_d = 1'b0;
                  for (int unsigned k = 0; k < NUM; k++) cnt_d[k] = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ACC;
         idx_q   <= '0;
         error_q <= 1'b0;
         for (int unsigned k = 0; k < NUM; k++) cnt_q[k] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         error_q <= error_d;
         for (int unsigned k = 0; k < NUM; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   assign bus.ready_o     = (state_q == ACC);
   assign bus.out_valid_o = (state_q == DUMP);
   assign bus.bin_o       = (state_q == DUMP) ? idx_q : '0;
   assign bus.count_o     = (state_q == DUMP) ? cnt_q[idx_q] : '0;
   assign bus.out_last_o  = (state_q == DUMP) && idx_last;
   assign bus.error_o     = error_q;
endmodule

// File: tb/tb_interval_hist.sv
// Directed bench for interval_hist: framed histograms, error flag, stalls, reset, wrap/saturate.
module tb_interval_hist;
   logic clk;
   logic rst_n;

   interval_hist_if #(.NUM(8), .CNT_W(16)) hif  ();
   interval_hist_if #(.NUM(8), .CNT_W(4))  hif4 ();

   interval_hist #(.NUM(8), .CNT_W(16)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (hif.slave)
   );

   interval_hist #(.NUM(8), .CNT_W(4)) dut4 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (hif4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int exp_cnt [8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic [7:0] code, input logic last);
      @(negedge clk);
      hif.valid_i    = 1'b1;
      hif.interval_i = code;
      hif.last_i     = last;
      @(posedge clk);
      #1;
      hif.valid_i = 1'b0;
      hif.last_i  = 1'b0;
   endtask

   // Drain with out_ready held high; entries must appear on 8 consecutive cycles.
   task automatic drain(input logic exp_err);
      hif.out_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("dump_valid%0d", i), hif.out_valid_o, 1);
         check($sformatf("dump_ready%0d", i), hif.ready_o, 0);
         check($sformatf("dump_bin%0d", i), hif.bin_o, i);
         check($sformatf("dump_cnt%0d", i), hif.count_o, exp_cnt[i]);
         check($sformatf("dump_last%0d", i), hif.out_last_o, (i == 7));
         check($sformatf("dump_err%0d", i), hif.error_o, exp_err);
      end
      @(posedge clk);
      #1;
      check("post_valid", hif.out_valid_o, 0);
      check("post_ready", hif.ready_o, 1);
      check("post_err", hif.error_o, 0);
      hif.out_ready_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int eidx;
      int cyc;
      logic r;
      logic [3:0] pat;
      int exp4;

      rst_n           = 1'b0;
      hif.valid_i     = 1'b0;
      hif.interval_i  = '0;
      hif.last_i      = 1'b0;
      hif.out_ready_i = 1'b0;
      hif4.valid_i    = 1'b0;
      hif4.interval_i = '0;
      hif4.last_i     = 1'b0;
      hif4.out_ready_i = 1'b0;

      #12;
      check("rst_ready", hif.ready_o, 1);
      check("rst_valid", hif.out_valid_o, 0);
      check("rst_bin", hif.bin_o, 0);
      check("rst_cnt", hif.count_o, 0);
      check("rst_err", hif.error_o, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic frame
      beat(8'h01, 1'b0);
      beat(8'h04, 1'b0);
      beat(8'h04, 1'b0);
      beat(8'h80, 1'b1);
      exp_cnt = '{1, 0, 2, 0, 0, 0, 0, 1};
      drain(1'b0);

      // Zero and multi-hot codes flag an error but do not count
      beat(8'h00, 1'b0);
      check("err_set", hif.error_o, 1);
      beat(8'h03, 1'b0);
      check("err_hold", hif.error_o, 1);
      beat(8'h10, 1'b1);
      exp_cnt = '{0, 0, 0, 0, 1, 0, 0, 0};
      drain(1'b1);

      // Stalled drain with valid_i held high throughout
      beat(8'h01, 1'b0);
      beat(8'h20, 1'b1);
      hif.valid_i    = 1'b1;
      hif.interval_i = 8'h01;
      exp_cnt = '{1, 0, 0, 0, 0, 1, 0, 0};
      pat  = 4'b1001;
      eidx = 0;
      cyc  = 0;
      while (eidx < 8 && cyc < 40) begin
         @(negedge clk);
         r = pat[cyc % 4];
         check("stall_valid", hif.out_valid_o, 1);
         check("stall_bin", hif.bin_o, eidx);
         check("stall_cnt", hif.count_o, exp_cnt[eidx]);
         hif.out_ready_i = r;
         @(posedge clk);
         if (r) eidx++;
         cyc++;
      end
      check("stall_done", eidx, 8);
      @(negedge clk);
      hif.valid_i     = 1'b0;
      hif.out_ready_i = 1'b0;
      check("stall_exit_ready", hif.ready_o, 1);
      check("stall_exit_valid", hif.out_valid_o, 0);

      // Reset in the middle of a dump
      beat(8'h01, 1'b0);
      beat(8'h02, 1'b1);
      hif.out_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("mid_bin", hif.bin_o, 3);
      hif.out_ready_i = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_valid", hif.out_valid_o, 0);
      check("arst_ready", hif.ready_o, 1);
      check("arst_bin", hif.bin_o, 0);
      check("arst_cnt", hif.count_o, 0);
      check("arst_last", hif.out_last_o, 0);
      check("arst_err", hif.error_o, 0);
      @(negedge clk);
      rst_n          = 1'b1;
      hif.valid_i    = 1'b1;
      hif.interval_i = 8'h08;
      hif.last_i     = 1'b1;
      @(posedge clk);
      #1;
      hif.valid_i = 1'b0;
      hif.last_i  = 1'b0;
      exp_cnt = '{0, 0, 0, 1, 0, 0, 0, 0};
      drain(1'b0);

      // Back-to-back frames, valid held across the dump
      beat(8'h01, 1'b0);
      @(negedge clk);
      hif.valid_i    = 1'b1;
      hif.interval_i = 8'h01;
      hif.last_i     = 1'b1;
      @(posedge clk);
      #1;
      hif.interval_i = 8'h40;
      hif.last_i     = 1'b0;
      exp_cnt = '{2, 0, 0, 0, 0, 0, 0, 0};
      drain(1'b0);
      @(posedge clk);
      #1;
      beat(8'h02, 1'b1);
      exp_cnt = '{0, 1, 0, 0, 0, 0, 1, 0};
      drain(1'b0);

      // 4-bit counters: 17 hits on bin 1
`ifdef INTERVAL_HIST_SAT_EN
      exp4 = 15;
`else
      exp4 = 1;
`endif
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         hif4.valid_i    = 1'b1;
         hif4.interval_i = 8'h02;
         hif4.last_i     = (i == 16);
      end
      @(posedge clk);
      #1;
      hif4.valid_i     = 1'b0;
      hif4.last_i      = 1'b0;
      hif4.out_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("w4_bin%0d", i), hif4.bin_o, i);
         check($sformatf("w4_cnt%0d", i), hif4.count_o, (i == 1) ? exp4 : 0);
      end
      @(posedge clk);
      #1;
      check("w4_post_valid", hif4.out_valid_o, 0);
      hif4.out_ready_i = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
